// File: rtl/mem_request_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_request_arbiter_pkg
//   Shared types and constants for the fetch / load-store memory arbiter.
//   - ADDR_TYPE / DATA_TYPE : default-width address and data words
//   - READ_FLAG / WRITE_FLAG: encoding of the load/store direction bit
//   - TRUE / FALSE          : single-bit pulse levels
//   - ZERO_WORD             : all-zero data word (reset and store read-back)
//   - ARB_STATE_TYPE        : 2-bit arbiter FSM encoding
// -----------------------------------------------------------------------------
package mem_request_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef logic [DEF_ADDR_W-1:0] ADDR_TYPE;
  typedef logic [DEF_DATA_W-1:0] DATA_TYPE;

  localparam logic READ_FLAG  = 1'b0;
  localparam logic WRITE_FLAG = 1'b1;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  localparam DATA_TYPE ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_IF = 2'b01,
    WAIT_LS = 2'b10
  } ARB_STATE_TYPE;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_request_arbiter_if
//   Bundles the fetch port, the load/store port and the memory-controller
//   port of the arbiter.
//   - slave  : the arbiter's view (takes requests and finishes, drives
//              readies, responses and controller commands)
//   - master : the surrounding system's view (requesters + controller)
// -----------------------------------------------------------------------------
interface mem_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction fetch side
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_pc;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_inst;

  // Load/store side
  logic              ls_req_valid;
  logic              ls_req_we;
  logic [2:0]        ls_req_len;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_req_ready;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_resp_rdata;

  // Memory controller side
  logic              mc_start_query;
  logic [ADDR_W-1:0] mc_query_pc;
  logic              mc_finish_query;
  logic [DATA_W-1:0] mc_inst;
  logic              mc_start_access;
  logic              mc_rw;
  logic [2:0]        mc_len;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_finish_rw;
  logic [DATA_W-1:0] mc_load_data;

  modport slave (
    input  if_req_valid, if_req_pc,
    output if_req_ready, if_resp_valid, if_resp_inst,
    input  ls_req_valid, ls_req_we, ls_req_len, ls_req_addr, ls_req_wdata,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output mc_start_query, mc_query_pc,
    input  mc_finish_query, mc_inst,
    output mc_start_access, mc_rw, mc_len, mc_addr, mc_wdata,
    input  mc_finish_rw, mc_load_data
  );

  modport master (
    output if_req_valid, if_req_pc,
    input  if_req_ready, if_resp_valid, if_resp_inst,
    output ls_req_valid, ls_req_we, ls_req_len, ls_req_addr, ls_req_wdata,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  mc_start_query, mc_query_pc,
    output mc_finish_query, mc_inst,
    input  mc_start_access, mc_rw, mc_len, mc_addr, mc_wdata,
    output mc_finish_rw, mc_load_data
  );

endinterface

// File: rtl/mem_request_arbiter_slot.sv
// -----------------------------------------------------------------------------
// mem_req_slot
//   Single-entry request holding register.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     en           : global enable; low freezes the entry
//     set          : capture payload_in and mark the entry pending
//     clr          : entry has been granted, release it
//     kill         : discard the entry (flush)
//     payload_in   : request payload to capture
//     pend         : entry holds a request
//     payload      : captured payload
//   clr/kill win over set; the owner only raises set while the entry is empty,
//   so the priority only matters when a kill races a new request.
// -----------------------------------------------------------------------------
module mem_req_slot #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 set,
  input  logic                 clr,
  input  logic                 kill,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 pend,
  output logic [PAYLOAD_W-1:0] payload
);

  logic                 pend_r;
  logic [PAYLOAD_W-1:0] payload_r;

  // Entry occupancy and payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r    <= 1'b0;
      payload_r <= {PAYLOAD_W{1'b0}};
    end else if (en) begin
      if (kill || clr) begin
        pend_r <= 1'b0;
      end else if (set) begin
        pend_r    <= 1'b1;
        payload_r <= payload_in;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign pend    = pend_r;
  assign payload = payload_r;

endmodule

// File: rtl/mem_request_arbiter.sv
// -----------------------------------------------------------------------------
// mem_request_arbiter
//   Single-outstanding arbiter between instruction fetch, the load/store unit
//   and a byte-serial memory controller. One fetch and one load/store request
//   are buffered; load/store wins unless fetch has been passed over
//   STARVE_LIMIT times in a row. Completions are routed back to the requester
//   and fetch work is discarded on a pipeline flush.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     rdy    : global enable; low freezes all state, pulses forced low
//     flush  : pipeline flush, kills buffered/in-flight fetch work
//     bus    : fetch, load/store and memory-controller signals (slave view)
// -----------------------------------------------------------------------------
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  mem_request_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int LS_W  = 1 + 3 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO  = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};

  // Slot interface
  logic              if_pend_s;
  logic              ls_pend_s;
  logic              if_req_ready_s;
  logic              ls_req_ready_s;
  logic              if_set_s;
  logic              ls_set_s;
  logic [ADDR_W-1:0] if_pc_s;
  logic [LS_W-1:0]   ls_payload_in_s;
  logic [LS_W-1:0]   ls_payload_s;
  logic              ls_we_s;
  logic [2:0]        ls_len_s;
  logic [ADDR_W-1:0] ls_addr_s;
  logic [DATA_W-1:0] ls_wdata_s;

  // Arbitration decision for this cycle
  logic              grant_if_s;
  logic              grant_ls_s;

  // FSM, counter and registered outputs
  ARB_STATE_TYPE     state_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              drop_r;
  logic              if_resp_valid_r;
  logic [DATA_W-1:0] if_resp_inst_r;
  logic              ls_resp_valid_r;
  logic [DATA_W-1:0] ls_resp_rdata_r;
  logic              mc_start_query_r;
  logic [ADDR_W-1:0] mc_query_pc_r;
  logic              mc_start_access_r;
  logic              mc_rw_r;
  logic [2:0]        mc_len_r;
  logic [ADDR_W-1:0] mc_addr_r;
  logic [DATA_W-1:0] mc_wdata_r;

  // A flushing cycle must not capture a fetch that belongs to the dead path.
  assign if_req_ready_s = !if_pend_s && !flush;
  assign ls_req_ready_s = !ls_pend_s;
  assign if_set_s       = bus.if_req_valid && if_req_ready_s;
  assign ls_set_s       = bus.ls_req_valid && ls_req_ready_s;

  assign ls_payload_in_s = {bus.ls_req_we, bus.ls_req_len, bus.ls_req_addr, bus.ls_req_wdata};
  assign {ls_we_s, ls_len_s, ls_addr_s, ls_wdata_s} = ls_payload_s;

  mem_req_slot #(
    .PAYLOAD_W (ADDR_W)
  ) u_if_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rdy),
    .set        (if_set_s),
    .clr        (grant_if_s),
    .kill       (flush),
    .payload_in (bus.if_req_pc),
    .pend       (if_pend_s),
    .payload    (if_pc_s)
  );

  mem_req_slot #(
    .PAYLOAD_W (LS_W)
  ) u_ls_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rdy),
    .set        (ls_set_s),
    .clr        (grant_ls_s),
    .kill       (1'b0),
    .payload_in (ls_payload_in_s),
    .pend       (ls_pend_s),
    .payload    (ls_payload_s)
  );

  // Grant selection: LS first, fetch once it has been passed over STARVE_LIMIT times
  always_comb begin
    grant_if_s = FALSE;
    grant_ls_s = FALSE;
    if (state_r == IDLE) begin
      if (if_pend_s && ls_pend_s) begin
        if (starve_cnt_r == STARVE_MAX) begin
          grant_if_s = TRUE;
        end else begin
          grant_ls_s = TRUE;
        end
      end else if (if_pend_s) begin
        grant_if_s = TRUE;
      end else if (ls_pend_s) begin
        grant_ls_s = TRUE;
      end else begin
        grant_if_s = FALSE;
        grant_ls_s = FALSE;
      end
    end else begin
      grant_if_s = FALSE;
      grant_ls_s = FALSE;
    end
  end

  // Starvation counter: counts LS grants that jumped a waiting fetch, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= CNT_ZERO;
    end else if (rdy) begin
      if (!if_pend_s || grant_if_s) begin
        starve_cnt_r <= CNT_ZERO;
      end else if (grant_ls_s && (starve_cnt_r != STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + CNT_ONE;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Arbiter FSM with registered controller commands and response latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      drop_r            <= FALSE;
      if_resp_valid_r   <= FALSE;
      if_resp_inst_r    <= DATA_ZERO;
      ls_resp_valid_r   <= FALSE;
      ls_resp_rdata_r   <= DATA_ZERO;
      mc_start_query_r  <= FALSE;
      mc_query_pc_r     <= ADDR_ZERO;
      mc_start_access_r <= FALSE;
      mc_rw_r           <= READ_FLAG;
      mc_len_r          <= 3'd0;
      mc_addr_r         <= ADDR_ZERO;
      mc_wdata_r        <= DATA_ZERO;
    end else if (rdy) begin
      // Pulses last exactly one enabled cycle.
      if_resp_valid_r   <= FALSE;
      ls_resp_valid_r   <= FALSE;
      mc_start_query_r  <= FALSE;
      mc_start_access_r <= FALSE;
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            mc_start_query_r <= TRUE;
            mc_query_pc_r    <= if_pc_s;
            state_r          <= WAIT_IF;
            // A flush racing the grant still launches the query, but its
            // result belongs to the killed path.
            drop_r           <= flush;
          end else if (grant_ls_s) begin
            mc_start_access_r <= TRUE;
            mc_rw_r           <= ls_we_s;
            mc_len_r          <= ls_len_s;
            mc_addr_r         <= ls_addr_s;
            mc_wdata_r        <= ls_wdata_s;
            state_r           <= WAIT_LS;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_IF: begin
          if (bus.mc_finish_query) begin
            if (!drop_r && !flush) begin
              if_resp_valid_r <= TRUE;
              if_resp_inst_r  <= bus.mc_inst;
            end
            state_r <= IDLE;
            drop_r  <= FALSE;
          end else if (flush) begin
            drop_r <= TRUE;
          end else begin
            drop_r <= drop_r;
          end
        end
        WAIT_LS: begin
          if (bus.mc_finish_rw) begin
            ls_resp_valid_r <= TRUE;
            ls_resp_rdata_r <= (mc_rw_r == WRITE_FLAG) ? DATA_ZERO : bus.mc_load_data;
            state_r         <= IDLE;
          end else begin
            state_r <= WAIT_LS;
          end
        end
        default: begin
          state_r <= IDLE;
          drop_r  <= FALSE;
        end
      endcase
    end else begin
      if_resp_valid_r   <= FALSE;
      ls_resp_valid_r   <= FALSE;
      mc_start_query_r  <= FALSE;
      mc_start_access_r <= FALSE;
    end
  end

  assign bus.if_req_ready    = if_req_ready_s;
  assign bus.ls_req_ready    = ls_req_ready_s;
  assign bus.if_resp_valid   = if_resp_valid_r;
  assign bus.if_resp_inst    = if_resp_inst_r;
  assign bus.ls_resp_valid   = ls_resp_valid_r;
  assign bus.ls_resp_rdata   = ls_resp_rdata_r;
  assign bus.mc_start_query  = mc_start_query_r;
  assign bus.mc_query_pc     = mc_query_pc_r;
  assign bus.mc_start_access = mc_start_access_r;
  assign bus.mc_rw           = mc_rw_r;
  assign bus.mc_len          = mc_len_r;
  assign bus.mc_addr         = mc_addr_r;
  assign bus.mc_wdata        = mc_wdata_r;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_request_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model of the arbiter predicts every output each cycle; a simple memory
//   controller model answers start pulses after a latency.
// -----------------------------------------------------------------------------
module tb_mem_request_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;

  mem_request_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_request_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model state ----------------
  bit          m_if_pend, m_ls_pend, m_ls_we, m_drop;
  logic [31:0] m_if_pc, m_ls_addr, m_ls_wdata;
  logic [2:0]  m_ls_len;
  int          m_busy;    // 0 nothing outstanding, 1 fetch, 2 load/store
  int          m_starve;
  bit          e_if_v, e_ls_v, e_sq, e_sa, e_rw;
  logic [31:0] e_if_inst, e_ls_rdata, e_qpc, e_addr, e_wdata;
  logic [2:0]  e_len;

  // ---------------- controller model state ----------------
  int          q_cnt, a_cnt, ctl_lat;
  bit          ctl_rand;
  logic [31:0] ctl_inst, ctl_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_if_pend = 0; m_ls_pend = 0; m_ls_we = 0; m_drop = 0;
    m_if_pc = 0; m_ls_addr = 0; m_ls_wdata = 0; m_ls_len = 0;
    m_busy = 0; m_starve = 0;
    e_if_v = 0; e_ls_v = 0; e_sq = 0; e_sa = 0; e_rw = 0;
    e_if_inst = 0; e_ls_rdata = 0; e_qpc = 0; e_addr = 0; e_wdata = 0; e_len = 0;
  endfunction

  // One rising edge of the arbiter, from the rules: who wins, what completes, what is captured.
  function automatic void model_step();
    int who;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_if_v = 0; e_ls_v = 0; e_sq = 0; e_sa = 0;
    if (!rdy) return;
    who = 0;
    if (m_busy == 0) begin
      if (m_ls_pend && !(m_if_pend && m_starve >= LIM)) who = 2;
      else if (m_if_pend) who = 1;
    end
    if (m_busy == 1) begin
      if (bus.mc_finish_query) begin
        if (!m_drop && !flush) begin e_if_v = 1; e_if_inst = bus.mc_inst; end
        m_busy = 0; m_drop = 0;
      end else if (flush) m_drop = 1;
    end else if (m_busy == 2 && bus.mc_finish_rw) begin
      e_ls_v = 1;
      e_ls_rdata = e_rw ? 32'h0 : bus.mc_load_data;
      m_busy = 0;
    end
    if (who == 1) begin
      e_sq = 1; e_qpc = m_if_pc; m_busy = 1; m_drop = flush;
    end else if (who == 2) begin
      e_sa = 1; e_rw = m_ls_we; e_len = m_ls_len; e_addr = m_ls_addr; e_wdata = m_ls_wdata;
      m_busy = 2;
    end
    if (!m_if_pend || who == 1) m_starve = 0;
    else if (who == 2 && m_starve < LIM) m_starve++;
    if (flush) m_if_pend = 0;
    else if (m_if_pend) m_if_pend = (who != 1);
    else if (bus.if_req_valid) begin m_if_pend = 1; m_if_pc = bus.if_req_pc; end
    if (m_ls_pend) m_ls_pend = (who != 2);
    else if (bus.ls_req_valid) begin
      m_ls_pend = 1; m_ls_we = bus.ls_req_we; m_ls_len = bus.ls_req_len;
      m_ls_addr = bus.ls_req_addr; m_ls_wdata = bus.ls_req_wdata;
    end
  endfunction

  task automatic compare();
    chk("if_req_ready",    bus.if_req_ready,    !m_if_pend && !flush);
    chk("ls_req_ready",    bus.ls_req_ready,    !m_ls_pend);
    chk("if_resp_valid",   bus.if_resp_valid,   e_if_v);
    chk("if_resp_inst",    bus.if_resp_inst,    e_if_inst);
    chk("ls_resp_valid",   bus.ls_resp_valid,   e_ls_v);
    chk("ls_resp_rdata",   bus.ls_resp_rdata,   e_ls_rdata);
    chk("mc_start_query",  bus.mc_start_query,  e_sq);
    chk("mc_query_pc",     bus.mc_query_pc,     e_qpc);
    chk("mc_start_access", bus.mc_start_access, e_sa);
    chk("mc_rw",           bus.mc_rw,           e_rw);
    chk("mc_len",          bus.mc_len,          e_len);
    chk("mc_addr",         bus.mc_addr,         e_addr);
    chk("mc_wdata",        bus.mc_wdata,        e_wdata);
  endtask

  // Memory controller: answers each start after ctl_lat cycles; a finish that
  // meets a frozen (rdy low) edge is held until it is seen.
  function automatic void ctl_update();
    int lat;
    if (!rst_n) begin
      q_cnt = 0; a_cnt = 0; bus.mc_finish_query = 0; bus.mc_finish_rw = 0;
      return;
    end
    if (rdy) begin bus.mc_finish_query = 0; bus.mc_finish_rw = 0; end
    lat = ctl_rand ? int'($urandom_range(1, 5)) : ctl_lat;
    if (bus.mc_start_query) q_cnt = lat;
    else if (q_cnt > 0) begin
      q_cnt--;
      if (q_cnt == 0) begin
        bus.mc_finish_query = 1;
        bus.mc_inst = ctl_rand ? $urandom : ctl_inst;
      end
    end else if (ctl_rand && !bus.mc_finish_query && $urandom_range(0, 40) == 0) begin
      bus.mc_finish_query = 1; bus.mc_inst = $urandom;
    end
    if (bus.mc_start_access) a_cnt = lat;
    else if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        bus.mc_finish_rw = 1;
        bus.mc_load_data = ctl_rand ? $urandom : ctl_data;
      end
    end else if (ctl_rand && !bus.mc_finish_rw && $urandom_range(0, 40) == 0) begin
      bus.mc_finish_rw = 1; bus.mc_load_data = $urandom;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    ctl_update();
  endtask

  task automatic set_if(input bit v, input logic [31:0] pc);
    bus.if_req_valid = v; bus.if_req_pc = pc;
  endtask

  task automatic set_ls(input bit v, input bit we, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] wd);
    bus.ls_req_valid = v; bus.ls_req_we = we; bus.ls_req_len = len;
    bus.ls_req_addr = addr; bus.ls_req_wdata = wd;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return bus.mc_start_query;
      1:       return bus.mc_start_access;
      2:       return bus.if_resp_valid;
      default: return bus.ls_resp_valid;
    endcase
  endfunction

  // Step until the selected output is high; n is the number of edges taken.
  task automatic wait_sig(input int sel, input string nm, output int n);
    n = 0;
    do begin step(); n++; end while (!sig(sel) && n < 100);
    if (!sig(sel)) chk({"timeout_", nm}, 32'(n), 32'd0);
  endtask

  task automatic drain(input int k);
    set_if(0, 0); set_ls(0, 0, 0, 0, 0);
    for (int i = 0; i < k; i++) step();
  endtask

  int n, n_ls, n_resp;

  initial begin
    rst_n = 0; rdy = 1; flush = 0;
    set_if(0, 0); set_ls(0, 0, 0, 0, 0);
    bus.mc_finish_query = 0; bus.mc_inst = 0; bus.mc_finish_rw = 0; bus.mc_load_data = 0;
    ctl_rand = 0; ctl_lat = 2; ctl_inst = 0; ctl_data = 0; q_cnt = 0; a_cnt = 0;
    model_reset();
    step(); step();
    rst_n = 1;
    chk("reset_if_ready", bus.if_req_ready, 1'b1);
    chk("reset_ls_ready", bus.ls_req_ready, 1'b1);
    chk("reset_mc_addr",  bus.mc_addr, 32'h0);

    // Lone fetch
    ctl_inst = 32'h0000_0013;
    set_if(1, 32'h100); step(); set_if(0, 0);
    wait_sig(0, "fetch_start", n);
    chk("fetch_start_latency", 32'(n), 32'd1);
    chk("fetch_query_pc", bus.mc_query_pc, 32'h100);
    wait_sig(2, "fetch_resp", n);
    chk("fetch_inst", bus.if_resp_inst, 32'h0000_0013);
    step();
    chk("fetch_resp_one_cycle", bus.if_resp_valid, 1'b0);
    drain(4);

    // Store completion
    ctl_data = 32'hDEAD_BEEF;
    set_ls(1, 1, 3'd1, 32'h3_0000, 32'h41); step(); set_ls(0, 0, 0, 0, 0);
    wait_sig(1, "store_start", n);
    chk("store_rw",  bus.mc_rw, 1'b1);
    chk("store_len", bus.mc_len, 3'd1);
    chk("store_addr", bus.mc_addr, 32'h3_0000);
    chk("store_wdata", bus.mc_wdata, 32'h41);
    wait_sig(3, "store_resp", n);
    chk("store_rdata", bus.ls_resp_rdata, 32'h0);
    drain(4);

    // Simultaneous requests: LS first, fetch right after the LS completes
    ctl_data = 32'hCAFE_0001; ctl_inst = 32'h0000_0033;
    set_if(1, 32'h200); set_ls(1, 0, 3'd4, 32'h1000, 0); step();
    set_if(0, 0); set_ls(0, 0, 0, 0, 0);
    step();
    chk("simul_ls_first", bus.mc_start_access, 1'b1);
    chk("simul_no_query", bus.mc_start_query, 1'b0);
    wait_sig(3, "simul_ls_resp", n);
    chk("simul_load_data", bus.ls_resp_rdata, 32'hCAFE_0001);
    wait_sig(0, "simul_if_start", n);
    chk("simul_if_gap", 32'(n), 32'd1);
    chk("simul_if_pc", bus.mc_query_pc, 32'h200);
    drain(6);

    // Starvation: LS requested continuously while fetch waits
    set_if(1, 32'h500); set_ls(1, 0, 3'd2, 32'h2000, 0); step(); set_if(0, 0);
    n_ls = 0; n = 0;
    while (!bus.mc_start_query && n < 300) begin
      step(); n++;
      if (bus.mc_start_access) n_ls++;
    end
    chk("starve_ls_grants", 32'(n_ls), 32'd4);
    chk("starve_if_pc", bus.mc_query_pc, 32'h500);
    // A second fetch must again wait exactly STARVE_LIMIT grants (counter cleared).
    set_if(1, 32'h504); step(); set_if(0, 0);
    n_ls = 0; n = 0;
    while (!bus.mc_start_query && n < 300) begin
      step(); n++;
      if (bus.mc_start_access) n_ls++;
    end
    chk("starve_ls_grants_again", 32'(n_ls), 32'd4);
    drain(12);

    // Flush while waiting for a fetch
    ctl_lat = 3; ctl_inst = 32'h1111_1111;
    set_if(1, 32'h300); step(); set_if(0, 0);
    wait_sig(0, "flush_start", n);
    flush = 1; step(); flush = 0;
    n_resp = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus.if_resp_valid) n_resp++; end
    chk("flush_no_resp", 32'(n_resp), 32'd0);
    ctl_inst = 32'h0000_0093;
    set_if(1, 32'h400); step(); set_if(0, 0);
    wait_sig(2, "post_flush_resp", n);
    chk("post_flush_inst", bus.if_resp_inst, 32'h0000_0093);
    drain(4);

    // rdy low with both slots pending
    set_if(1, 32'h600); set_ls(1, 0, 3'd2, 32'h2200, 0); step();
    set_if(0, 0); set_ls(0, 0, 0, 0, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_low_no_start", 32'(bus.mc_start_query | bus.mc_start_access), 32'd0);
    end
    rdy = 1; step();
    chk("rdy_back_ls_start", bus.mc_start_access, 1'b1);
    drain(16);

    // Asynchronous reset in the middle of a load/store access
    ctl_lat = 6;
    set_ls(1, 1, 3'd4, 32'h4000, 32'h5A5A_5A5A); step(); set_ls(0, 0, 0, 0, 0);
    wait_sig(1, "rst_ls_start", n);
    #2 rst_n = 0;
    #1;
    chk("async_rst_addr",  bus.mc_addr, 32'h0);
    chk("async_rst_wdata", bus.mc_wdata, 32'h0);
    chk("async_rst_rw",    bus.mc_rw, 1'b0);
    chk("async_rst_len",   bus.mc_len, 3'd0);
    chk("async_rst_pulse", 32'(bus.mc_start_access | bus.ls_resp_valid), 32'd0);
    model_reset();
    step(); step();
    rst_n = 1;
    drain(2);

    // Randomized traffic
    ctl_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      set_if($urandom_range(0, 2) == 0, {$urandom_range(0, 255), 2'b00});
      case ($urandom_range(0, 2))
        0:       set_ls($urandom_range(0, 1) == 0, 1'($urandom_range(0, 1)), 3'd1, $urandom, $urandom);
        1:       set_ls($urandom_range(0, 1) == 0, 1'($urandom_range(0, 1)), 3'd2, $urandom, $urandom);
        default: set_ls($urandom_range(0, 1) == 0, 1'($urandom_range(0, 1)), 3'd4, $urandom, $urandom);
      endcase
      step();
    end
    rst_n = 1; rdy = 1; flush = 0;
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
